dqs_write_burst_gen: RTL and testbench



---
 rtl/dqs_write_burst_gen_pkg.sv | 30 +++
 rtl/dqs_write_burst_gen.sv | 126 ++++++++++++
 tb/tb_dqs_write_burst_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dqs_write_burst_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dqs_tx_pkg                                                           |
// | States and serializer/output-enable words for the DQS write driver.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dqs_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LAT = 3'd1,
    PRE      = 3'd2,
    BURST    = 3'd3,
    POST     = 3'd4
  } dqs_state_e;

  // TX bit0 / OE bit0 are the earliest UI of the FAB_CLK cycle
  localparam logic [7:0] TX_IDLE   = 8'h00;
  localparam logic [7:0] TX_PRE1   = 8'h00;
  localparam logic [7:0] TX_PRE2   = 8'b0001_0000;
  localparam logic [7:0] TX_TOGGLE = 8'b0101_0101;

  localparam logic [3:0] OE_IDLE   = 4'b0000;
  localparam logic [3:0] OE_PRE1   = 4'b1000;
  localparam logic [3:0] OE_PRE2   = 4'b1100;
  localparam logic [3:0] OE_BURST  = 4'b1111;
  localparam logic [3:0] OE_POST   = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/dqs_write_burst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dqs_write_burst_gen                                                  |
// | DQS lane transmit driver: latency wait, preamble, BL8 bursts,        |
// | postamble. All outputs registered one cycle behind the FSM state.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dqs_write_burst_gen
  import dqs_tx_pkg::*;
#(
  parameter int WR_LAT = 2,
  parameter int BCNT_W = 4
) (
  input  logic              FAB_CLK,
  input  logic              ARST,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [BCNT_W-1:0] WR_BURSTS,
  input  logic              PRE_2TCK,
  output logic [7:0]        TX_DATA,
  output logic [3:0]        OE_DATA,
  output logic              DQ_BURST,
  output logic              BUSY
);

  // Shared down-counter must hold both the latency and the burst count
  localparam int CNT_W = (BCNT_W > 4) ? BCNT_W : 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_LOAD = (WR_LAT > 0) ? CNT_W'(WR_LAT - 1) : '0;

  dqs_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCNT_W-1:0] bursts_q, bursts_d;
  logic              pre2_q, pre2_d;
  logic [7:0]        tx_q, tx_d;
  logic [3:0]        oe_q, oe_d;
  logic              dq_burst_q, dq_burst_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bursts_d   = bursts_q;
    pre2_d     = pre2_q;
    tx_d       = TX_IDLE;
    oe_d       = OE_IDLE;
    dq_burst_d = 1'b0;
    accept     = WR_VALID & ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bursts_d = WR_BURSTS;
          pre2_d   = PRE_2TCK;
          if (WR_LAT > 0) begin
            state_d = WAIT_LAT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = PRE;
          end
        end
      end
      WAIT_LAT: begin
        if (cnt_q == '0) state_d = PRE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      PRE: begin
        tx_d    = pre2_q ? TX_PRE2 : TX_PRE1;
        oe_d    = pre2_q ? OE_PRE2 : OE_PRE1;
        state_d = BURST;
        cnt_d   = CNT_W'(bursts_q);
      end
      BURST: begin
        tx_d       = TX_TOGGLE;
        oe_d       = OE_BURST;
        dq_burst_d = 1'b1;
        // Exit on zero rather than decrementing past it, so max count cannot wrap
        if (cnt_q == '0) state_d = POST;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      POST: begin
        oe_d    = OE_POST;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready returns only once the postamble word has left the output register
    ready_d = (state_q == IDLE) && !accept;
    busy_d  = !ready_d;
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bursts_q   <= '0;
      pre2_q     <= 1'b0;
      tx_q       <= TX_IDLE;
      oe_q       <= OE_IDLE;
      dq_burst_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bursts_q   <= bursts_d;
      pre2_q     <= pre2_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      dq_burst_q <= dq_burst_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign WR_READY = ready_q;
  assign BUSY     = busy_q;
  assign TX_DATA  = tx_q;
  assign OE_DATA  = oe_q;
  assign DQ_BURST = dq_burst_q;

endmodule
`default_nettype wire

// File: tb/tb_dqs_write_burst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dqs_write_burst_gen                                               |
// | Directed bench: WR_LAT=2 instance and WR_LAT=0 instance.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dqs_write_burst_gen;

  logic       clk;
  logic       rst;

  logic       v2, p2, rdy2, dq2, busy2;
  logic [3:0] b2, oe2;
  logic [7:0] tx2;

  logic       v0, p0, rdy0, dq0, busy0;
  logic [3:0] b0, oe0;
  logic [7:0] tx0;

  int vec  = 0;
  int miss = 0;

  dqs_write_burst_gen #(.WR_LAT(2), .BCNT_W(4)) u_lat2 (
    .FAB_CLK  (clk),
    .ARST     (rst),
    .WR_VALID (v2),
    .WR_READY (rdy2),
    .WR_BURSTS(b2),
    .PRE_2TCK (p2),
    .TX_DATA  (tx2),
    .OE_DATA  (oe2),
    .DQ_BURST (dq2),
    .BUSY     (busy2)
  );

  dqs_write_burst_gen #(.WR_LAT(0), .BCNT_W(4)) u_lat0 (
    .FAB_CLK  (clk),
    .ARST     (rst),
    .WR_VALID (v0),
    .WR_READY (rdy0),
    .WR_BURSTS(b0),
    .PRE_2TCK (p0),
    .TX_DATA  (tx0),
    .OE_DATA  (oe0),
    .DQ_BURST (dq0),
    .BUSY     (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [7:0] etx, input logic [3:0] eoe,
                      input logic edq, input logic erdy);
    chk({tag, "_tx2"},   32'(tx2),   32'(etx));
    chk({tag, "_oe2"},   32'(oe2),   32'(eoe));
    chk({tag, "_dq2"},   32'(dq2),   32'(edq));
    chk({tag, "_rdy2"},  32'(rdy2),  32'(erdy));
    chk({tag, "_busy2"}, 32'(busy2), 32'(!erdy));
  endtask

  task automatic chk0(input string tag, input logic [7:0] etx, input logic [3:0] eoe,
                      input logic edq, input logic erdy);
    chk({tag, "_tx0"},   32'(tx0),   32'(etx));
    chk({tag, "_oe0"},   32'(oe0),   32'(eoe));
    chk({tag, "_dq0"},   32'(dq0),   32'(edq));
    chk({tag, "_rdy0"},  32'(rdy0),  32'(erdy));
    chk({tag, "_busy0"}, 32'(busy0), 32'(!erdy));
  endtask

  initial begin
    rst = 1'b1;
    v2 = 1'b0; b2 = 4'd0; p2 = 1'b0;
    v0 = 1'b0; b0 = 4'd0; p0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk2("idle", 8'h00, 4'h0, 1'b0, 1'b1);
      chk0("idle", 8'h00, 4'h0, 1'b0, 1'b1);
    end

    // WR_LAT=2, single burst, 1tCK preamble
    v2 = 1'b1; b2 = 4'd0; p2 = 1'b0;
    step(); v2 = 1'b0;
    chk2("a_acc",   8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("a_wait1", 8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("a_wait2", 8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("a_pre",   8'h00, 4'h8, 1'b0, 1'b0);
    step(); chk2("a_burst", 8'h55, 4'hF, 1'b1, 1'b0);
    step(); chk2("a_post",  8'h00, 4'h1, 1'b0, 1'b0);
    step(); chk2("a_rdy",   8'h00, 4'h0, 1'b0, 1'b1);

    // Max bursts, 2tCK preamble; inputs changed while busy must not matter
    v2 = 1'b1; b2 = 4'd15; p2 = 1'b1;
    step(); v2 = 1'b0; b2 = 4'd3; p2 = 1'b0;
    chk2("b_acc", 8'h00, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); chk2("b_wait", 8'h00, 4'h0, 1'b0, 1'b0);
    end
    step(); chk2("b_pre", 8'h10, 4'hC, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(); chk2("b_burst", 8'h55, 4'hF, 1'b1, 1'b0);
    end
    step(); chk2("b_post", 8'h00, 4'h1, 1'b0, 1'b0);
    step(); chk2("b_rdy",  8'h00, 4'h0, 1'b0, 1'b1);

    // Next request picks up the new values: 4 bursts, 1tCK preamble
    v2 = 1'b1;
    step(); v2 = 1'b0;
    chk2("c_acc", 8'h00, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); chk2("c_wait", 8'h00, 4'h0, 1'b0, 1'b0);
    end
    step(); chk2("c_pre", 8'h00, 4'h8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk2("c_burst", 8'h55, 4'hF, 1'b1, 1'b0);
    end
    step(); chk2("c_post", 8'h00, 4'h1, 1'b0, 1'b0);
    step(); chk2("c_rdy",  8'h00, 4'h0, 1'b0, 1'b1);

    // WR_LAT=0 with WR_VALID held: one accept every 5 cycles
    v0 = 1'b1; b0 = 4'd0; p0 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step(); chk0("d_acc",   8'h00, 4'h0, 1'b0, 1'b0);
      step(); chk0("d_pre",   8'h00, 4'h8, 1'b0, 1'b0);
      step(); chk0("d_burst", 8'h55, 4'hF, 1'b1, 1'b0);
      step(); chk0("d_post",  8'h00, 4'h1, 1'b0, 1'b0);
      step(); chk0("d_rdy",   8'h00, 4'h0, 1'b0, 1'b1);
    end
    v0 = 1'b0;

    // Asynchronous reset during the 3rd burst cycle
    v2 = 1'b1; b2 = 4'd7; p2 = 1'b0;
    step(); v2 = 1'b0;
    step(); step();
    step(); chk2("e_pre", 8'h00, 4'h8, 1'b0, 1'b0);
    step(); step();
    step(); chk2("e_burst3", 8'h55, 4'hF, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk2("e_arst", 8'h00, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step(); chk2("e_idle", 8'h00, 4'h0, 1'b0, 1'b1);

    // Full sequence after reset recovery
    v2 = 1'b1; b2 = 4'd0; p2 = 1'b1;
    step(); v2 = 1'b0;
    chk2("f_acc", 8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("f_wait1", 8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("f_wait2", 8'h00, 4'h0, 1'b0, 1'b0);
    step(); chk2("f_pre",   8'h10, 4'hC, 1'b0, 1'b0);
    step(); chk2("f_burst", 8'h55, 4'hF, 1'b1, 1'b0);
    step(); chk2("f_post",  8'h00, 4'h1, 1'b0, 1'b0);
    step(); chk2("f_rdy",   8'h00, 4'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
